cond_unit_mb: RTL and testbench

COND_UNIT_MB -- requirements
Module: cond_unit_mb

---
 rtl/cond_unit_mb.sv | 112 +++++++++++
 tb/tb_cond_unit_mb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_unit_mb.sv
// rtl/cond_unit_mb.sv - banked NZCV condition unit with shadow save/restore
// Decodes ARM conditions against the selected flag bank and registers the result into Memory.
module cond_unit_mb #(
  parameter int NBANKS = 2,
  parameter int BW     = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stallE,
  input  logic          flushE,
  input  logic [BW-1:0] bankE,
  input  logic [3:0]    condE,
  input  logic [1:0]    FlagWriteE,
  input  logic [3:0]    ALU_flags,
  input  logic          save_en,
  input  logic          restore_en,
  output logic          condEx,
  output logic          undefE,
  output logic [3:0]    flagsE_out,
  output logic          condExM
);

  logic [3:0] flags  [NBANKS];
  logic [3:0] shadow [NBANKS];

  logic [NBANKS-1:0] bank_sel;
  logic [3:0]        cur_flags;
  logic [3:0]        cur_shadow;
  logic              raw_cond;
  logic              flag_n, flag_z, flag_c, flag_v;
  logic              write_nz, write_cv;
  logic              do_save, do_restore;
  logic [3:0]        next_flags;

  // An out-of-range bank matches no entry, so it reads zero and selects nothing to update.
  always_comb begin
    bank_sel   = '0;
    cur_flags  = 4'b0000;
    cur_shadow = 4'b0000;
    for (int i = 0; i < NBANKS; i++) begin
      if (bankE == BW'(i)) begin
        bank_sel[i] = 1'b1;
        cur_flags   = flags[i];
        cur_shadow  = shadow[i];
      end
    end
  end

  assign flagsE_out = cur_flags;
  assign flag_n     = cur_flags[3];
  assign flag_z     = cur_flags[2];
  assign flag_c     = cur_flags[1];
  assign flag_v     = cur_flags[0];

  always_comb begin
    raw_cond = 1'b0;
    case (condE)
      4'b0000: raw_cond = flag_z;
      4'b0001: raw_cond = !flag_z;
      4'b0010: raw_cond = flag_c;
      4'b0011: raw_cond = !flag_c;
      4'b0100: raw_cond = flag_n;
      4'b0101: raw_cond = !flag_n;
      4'b0110: raw_cond = flag_v;
      4'b0111: raw_cond = !flag_v;
      4'b1000: raw_cond = flag_c && !flag_z;
      4'b1001: raw_cond = !(flag_c && !flag_z);
      4'b1010: raw_cond = (flag_n == flag_v);
      4'b1011: raw_cond = (flag_n != flag_v);
      4'b1100: raw_cond = !flag_z && (flag_n == flag_v);
      4'b1101: raw_cond = !(!flag_z && (flag_n == flag_v));
      4'b1110: raw_cond = 1'b1;
      default: raw_cond = 1'b0;
    endcase
  end

  assign condEx = raw_cond && !flushE;
  assign undefE = (condE == 4'b1111) && !flushE;

  // Save/restore follow the flush but ignore the condition result.
  assign write_nz   = condEx && FlagWriteE[1];
  assign write_cv   = condEx && FlagWriteE[0];
  assign do_save    = save_en && !flushE;
  assign do_restore = restore_en && !flushE;

  always_comb begin
    next_flags = cur_flags;
    if (write_nz) next_flags[3:2] = ALU_flags[3:2];
    if (write_cv) next_flags[1:0] = ALU_flags[1:0];
    if (do_restore) next_flags = cur_shadow;
  end

  // Both sides read pre-edge values, so save+restore together swap flags and shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      condExM <= 1'b0;
      for (int i = 0; i < NBANKS; i++) begin
        flags[i]  <= 4'b0000;
        shadow[i] <= 4'b0000;
      end
    end else if (!stallE) begin
      condExM <= condEx;
      for (int i = 0; i < NBANKS; i++) begin
        if (bank_sel[i]) begin
          flags[i] <= next_flags;
          if (do_save) shadow[i] <= cur_flags;
        end
      end
    end
  end

endmodule

// File: tb/tb_cond_unit_mb.sv
// tb/tb_cond_unit_mb.sv - self-checking bench for cond_unit_mb
// Drives a 4-bank and a 3-bank instance in parallel against a behavioural model.
module tb_cond_unit_mb;

  logic       clk = 1'b0;
  logic       reset, stallE, flushE, save_en, restore_en;
  logic [1:0] bankE, FlagWriteE;
  logic [3:0] condE, ALU_flags;

  logic       cex   [2];
  logic       und   [2];
  logic [3:0] fo    [2];
  logic       cexm  [2];

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] mf  [2][4];
  logic [3:0] ms  [2][4];
  logic       mcm [2];
  int         nb  [2] = '{4, 3};

  always #5 clk = ~clk;

  cond_unit_mb #(.NBANKS(4), .BW(2)) dut4 (
    .clk(clk), .reset(reset), .stallE(stallE), .flushE(flushE), .bankE(bankE),
    .condE(condE), .FlagWriteE(FlagWriteE), .ALU_flags(ALU_flags),
    .save_en(save_en), .restore_en(restore_en), .condEx(cex[0]), .undefE(und[0]),
    .flagsE_out(fo[0]), .condExM(cexm[0])
  );

  cond_unit_mb #(.NBANKS(3), .BW(2)) dut3 (
    .clk(clk), .reset(reset), .stallE(stallE), .flushE(flushE), .bankE(bankE),
    .condE(condE), .FlagWriteE(FlagWriteE), .ALU_flags(ALU_flags),
    .save_en(save_en), .restore_en(restore_en), .condEx(cex[1]), .undefE(und[1]),
    .flagsE_out(fo[1]), .condExM(cexm[1])
  );

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  // Condition table written straight from the ARM condition definitions.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (int'(c))
      0:  return z;
      1:  return !z;
      2:  return cy;
      3:  return !cy;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return cy && !z;
      9:  return !cy || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] m_read(input int k);
    if (int'(bankE) < nb[k]) return mf[k][bankE];
    return 4'b0000;
  endfunction

  function automatic logic m_cex(input int k);
    return cond_pass(condE, m_read(k)) && !flushE;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mcm[k] = 1'b0;
      for (int b = 0; b < 4; b++) begin
        mf[k][b] = 4'b0000;
        ms[k][b] = 4'b0000;
      end
    end
  endtask

  task automatic model_update();
    logic [3:0] f, s, nf;
    logic       c;
    if (reset) begin
      model_clear();
      return;
    end
    if (stallE) return;
    for (int k = 0; k < 2; k++) begin
      c = m_cex(k);
      f = m_read(k);
      if (int'(bankE) < nb[k]) begin
        s  = ms[k][bankE];
        nf = f;
        if (c && FlagWriteE[1]) nf[3:2] = ALU_flags[3:2];
        if (c && FlagWriteE[0]) nf[1:0] = ALU_flags[1:0];
        if (restore_en && !flushE) nf = s;
        if (save_en && !flushE) ms[k][bankE] = f;
        mf[k][bankE] = nf;
      end
      mcm[k] = c;
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("flags%0d", k), fo[k], m_read(k));
      check($sformatf("condEx%0d", k), {3'b0, cex[k]}, {3'b0, m_cex(k)});
      check($sformatf("undefE%0d", k), {3'b0, und[k]},
            {3'b0, (condE == 4'hF) && !flushE});
      check($sformatf("condExM%0d", k), {3'b0, cexm[k]}, {3'b0, mcm[k]});
    end
  endtask

  task automatic step();
    #2;
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic [1:0] b, input logic [3:0] c, input logic [1:0] fw,
                       input logic [3:0] alu);
    bankE = b; condE = c; FlagWriteE = fw; ALU_flags = alu;
  endtask

  initial begin
    reset = 1'b1; stallE = 1'b0; flushE = 1'b0; save_en = 1'b0; restore_en = 1'b0;
    drive(2'd0, 4'hE, 2'b00, 4'h0);
    repeat (2) @(posedge clk);
    model_clear();
    #1;
    reset = 1'b0;
    #1;
    check("rst_flags", fo[0], 4'b0000);
    check("rst_condExM", {3'b0, cexm[0]}, 4'b0000);

    // Basic write then read-back, and bank isolation.
    drive(2'd0, 4'hE, 2'b11, 4'b0100);
    step();
    #1 check("w_flags", fo[0], 4'b0100);
    condE = 4'h0;
    #1 check("eq_pass", {3'b0, cex[0]}, 4'b0001);
    bankE = 2'd1;
    #1 check("bank1_zero", fo[0], 4'b0000);
    step();

    // Failed condition and flush block the write.
    drive(2'd0, 4'h1, 2'b11, 4'b1010);
    #1 check("ne_fail", {3'b0, cex[0]}, 4'b0000);
    step();
    flushE = 1'b1; condE = 4'hE;
    #1 check("flush_cex", {3'b0, cex[0]}, 4'b0000);
    step();
    flushE = 1'b0;
    #1 check("flush_cexm", {3'b0, cexm[0]}, 4'b0000);
    check("flush_flags", fo[0], 4'b0100);

    // Save alongside a write, then restore overriding a write.
    drive(2'd0, 4'hE, 2'b11, 4'b0010);
    step();
    save_en = 1'b1; ALU_flags = 4'b1001;
    step();
    save_en = 1'b0;
    #1 check("save_flags", fo[0], 4'b1001);
    restore_en = 1'b1; ALU_flags = 4'b0100;
    step();
    restore_en = 1'b0;
    #1 check("restore_flags", fo[0], 4'b0010);

    // Swap.
    ALU_flags = 4'b0001;
    step();
    save_en = 1'b1; FlagWriteE = 2'b00;
    step();
    save_en = 1'b0; FlagWriteE = 2'b11; ALU_flags = 4'b1000;
    step();
    save_en = 1'b1; restore_en = 1'b1; FlagWriteE = 2'b00;
    step();
    save_en = 1'b0;
    #1 check("swap_flags", fo[0], 4'b0001);
    step();
    restore_en = 1'b0;
    #1 check("swap_shadow", fo[0], 4'b1000);

    // Stall freezes everything; 1111 is undefined.
    stallE = 1'b1; save_en = 1'b1; FlagWriteE = 2'b11; ALU_flags = 4'b1111;
    repeat (3) step();
    stallE = 1'b0; save_en = 1'b0; FlagWriteE = 2'b00;
    #1 check("stall_flags", fo[0], 4'b1000);
    condE = 4'hF;
    #1 check("undef", {3'b0, und[0]}, 4'b0001);
    check("undef_cex", {3'b0, cex[0]}, 4'b0000);
    step();

    // Reset discards a same-cycle write.
    drive(2'd0, 4'hE, 2'b11, 4'b1111);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1 check("rst2_flags", fo[0], 4'b0000);
    check("rst2_cexm", {3'b0, cexm[0]}, 4'b0000);
    condE = 4'h0;
    #1 check("rst2_eq", {3'b0, cex[0]}, 4'b0000);
    condE = 4'h1;
    #1 check("rst2_ne", {3'b0, cex[0]}, 4'b0001);

    // Walk NZ writes across all banks (bank 3 is out of range on the 3-bank instance).
    for (int b = 0; b < 4; b++) begin
      drive(2'(b), 4'hE, 2'b10, 4'(b << 2));
      step();
    end
    FlagWriteE = 2'b00;
    for (int b = 0; b < 4; b++) begin
      bankE = 2'(b);
      #1 check($sformatf("walk4_b%0d", b), fo[0], 4'((b << 2) & 4'hC));
      check($sformatf("walk3_b%0d", b), fo[1], (b < 3) ? 4'((b << 2) & 4'hC) : 4'b0000);
      step();
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 59) == 0);
      stallE     = ($urandom_range(0, 3) == 0);
      flushE     = ($urandom_range(0, 5) == 0);
      save_en    = ($urandom_range(0, 4) == 0);
      restore_en = ($urandom_range(0, 4) == 0);
      drive(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
